uart_rx_ctrl: RTL and testbench

- Serial receive controller. Drives a flexcounter instance through its control signals and consumes the counter's strobe as the bit-sample tick.
- Converts an asynchronous serial line into 8-bit bytes and presents each byte to the key/character decode logic with a one-cycle valid pulse.
- Frame format is 8N1, LSB first. A parity bit is optional.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_t           receive FSM state encoding
//   DATA_BITS            payload bits per frame
//   DEFAULT_CLKS_PER_BIT clocks per serial bit at 100 MHz / 115200 baud
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: double-flop synchronizer for asynchronous inputs.
// Both stages reset to all-ones so an idle-high line looks idle out of reset.
// Ports:
//   clk   in   system clock
//   nRST  in   asynchronous active-low reset
//   d     in   asynchronous input  [WIDTH-1:0]
//   q     out  synchronized output [WIDTH-1:0]
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: serial receive controller (8N1, LSB first).
// Bit timing comes from an external flexcounter: this block drives its
// enable/clear/terminal value and uses its strobe as the sample tick.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a parity check;
// without it the frame is 8N1 and parity_error is tied low.
// Ports:
//   clk            in   system clock
//   nRST           in   asynchronous active-low reset
//   rx             in   raw serial line, asynchronous, idle high
//   strobe         in   flexcounter terminal-count pulse
//   enableCounter  out  flexcounter enable
//   clear          out  flexcounter synchronous clear
//   maxCount       out  flexcounter terminal value [COUNTWIDTH-1:0]
//   rx_data        out  last good byte received
//   rx_valid       out  one-cycle pulse when rx_data updates
//   frame_error    out  one-cycle pulse when the stop bit samples low
//   parity_error   out  one-cycle pulse on a parity mismatch
//   rx_busy        out  high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | line idle, counter held clear, waiting for rx_s low
// START  | timing half a bit to the middle of the start bit
// DATA   | sampling 8 data bits, one per full-bit strobe
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit and publishing the result
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int COUNTSIZE    = 1024,
    parameter int COUNTWIDTH   = $clog2(COUNTSIZE)
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  rx,
    input  logic                  strobe,
    output logic                  enableCounter,
    output logic                  clear,
    output logic [COUNTWIDTH-1:0] maxCount,
    output logic [DATA_BITS-1:0]  rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  parity_error,
    output logic                  rx_busy
);

    localparam int IDXW     = $clog2(DATA_BITS);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    localparam logic [COUNTWIDTH-1:0] MAX_HALF = COUNTWIDTH'(HALF_BIT - 1);
    localparam logic [COUNTWIDTH-1:0] MAX_FULL = COUNTWIDTH'(CLKS_PER_BIT - 1);
    localparam logic [IDXW-1:0]       LAST_BIT = IDXW'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 rx_s;
    logic [DATA_BITS-1:0] shift_reg;
    logic [IDXW-1:0]      bit_idx;

    logic start_data;
    logic do_shift;
    logic do_valid;
    logic do_ferr;
    logic parity_fault;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync_rx (
        .clk  (clk),
        .nRST (nRST),
        .d    (rx),
        .q    (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    logic do_parity;
    logic do_perr;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_fault = ^{shift_reg, parity_bit};
`else
    assign parity_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        enableCounter = 1'b1;
        clear         = 1'b0;
        maxCount      = MAX_FULL;
        start_data    = 1'b0;
        do_shift      = 1'b0;
        do_valid      = 1'b0;
        do_ferr       = 1'b0;
`ifdef UART_RX_PARITY_EN
        do_parity     = 1'b0;
        do_perr       = 1'b0;
`endif
        case (state)
            IDLE: begin
                enableCounter = 1'b0;
                clear         = 1'b1;
                maxCount      = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                maxCount = MAX_HALF;
                if (strobe) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        // Restart the counter so data strobes land mid-bit.
                        state_next = DATA;
                        clear      = 1'b1;
                        start_data = 1'b1;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    do_shift = 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (strobe) begin
                    do_parity  = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (strobe) begin
                    state_next = IDLE;
                    // A bad stop bit masks any parity result.
                    if (!rx_s) begin
                        do_ferr = 1'b1;
                    end else if (parity_fault) begin
`ifdef UART_RX_PARITY_EN
                        do_perr = 1'b1;
`endif
                    end else begin
                        do_valid = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            shift_reg   <= '0;
            bit_idx     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid    <= do_valid;
            frame_error <= do_ferr;
            if (start_data) begin
                bit_idx <= '0;
            end
            if (do_shift) begin
                shift_reg[bit_idx] <= rx_s;
                bit_idx            <= bit_idx + 1'b1;
            end
            if (do_valid) begin
                rx_data <= shift_reg;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            parity_bit   <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            parity_error <= do_perr;
            if (do_parity) begin
                parity_bit <= rx_s;
            end
        end
    end
`else
    assign parity_error = 1'b0;
`endif

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl with a behavioural
// flexcounter. Expected output pulses are queued as frames are sent and
// matched in order by a monitor on the falling clock edge.
// Honours UART_RX_PARITY_EN: frames then carry an even-parity bit.
module tb_uart_rx_ctrl;

    localparam int CLKS  = 16;
    localparam int CSIZE = 1024;
    localparam int CW    = $clog2(CSIZE);

    logic          clk = 1'b0;
    logic          nRST;
    logic          rx;
    logic          strobe;
    logic          enableCounter;
    logic          clear;
    logic [CW-1:0] maxCount;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          frame_error;
    logic          parity_error;
    logic          rx_busy;

    uart_rx_ctrl #(
        .CLKS_PER_BIT (CLKS),
        .COUNTSIZE    (CSIZE)
    ) dut (
        .clk           (clk),
        .nRST          (nRST),
        .rx            (rx),
        .strobe        (strobe),
        .enableCounter (enableCounter),
        .clear         (clear),
        .maxCount      (maxCount),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .frame_error   (frame_error),
        .parity_error  (parity_error),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    // Behavioural flexcounter following the contract the DUT relies on.
    logic [CW-1:0] count;
    assign strobe = enableCounter && (count == maxCount);

    always @(posedge clk or negedge nRST) begin
        if (!nRST)              count <= '0;
        else if (clear)         count <= '0;
        else if (enableCounter) count <= strobe ? '0 : count + 1'b1;
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [2:0] onehot;   // {parity_error, frame_error, rx_valid}
        logic [7:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            n_cmp = 0;
    int            n_err = 0;
    int            last_evt_cycle = 0;
    int            n_7to15 = 0;
    logic [CW-1:0] prev_max = '0;
    logic [7:0]    last_good = 8'h00;
    logic [2:0]    obs;

    always @(negedge clk) begin
        if (prev_max == CW'(7) && maxCount == CW'(15)) n_7to15++;
        prev_max = maxCount;
        obs = {parity_error, frame_error, rx_valid};
        if (obs != 3'b000) begin
            last_evt_cycle = cycle;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got pulses %b, wanted none", obs);
            end else begin
                e = sb.pop_front();
                if (obs !== e.onehot) begin
                    n_err++;
                    $display("FAIL pulse_kind: got %b, wanted %b", obs, e.onehot);
                end
                n_cmp++;
                if (rx_data !== e.data) begin
                    n_err++;
                    $display("FAIL rx_data_at_pulse: got %h, wanted %h", rx_data, e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, wanted finish");
        $fatal(1);
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic b);
        rx = b;
        repeat (CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stopb);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(par);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
        hold_bit(stopb);
        rx = 1'b1;
    endtask

    task automatic expect_valid(input logic [7:0] d);
        sb.push_back('{3'b001, d});
        last_good = d;
    endtask

    task automatic expect_ferr();
        sb.push_back('{3'b010, last_good});
    endtask

    task automatic expect_perr();
        sb.push_back('{3'b100, last_good});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d pulses outstanding, wanted 0", name, sb.size());
            sb.delete();
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        rx   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({enableCounter, clear, maxCount} !== {1'b0, 1'b1, CW'(0)}) begin
            n_err++;
            $display("FAIL reset_counter_ctrl: got en=%b clr=%b max=%0d, wanted en=0 clr=1 max=0",
                     enableCounter, clear, maxCount);
        end
        n_cmp++;
        if ({rx_data, rx_valid, frame_error, parity_error, rx_busy} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b pe=%b busy=%b, wanted all 0",
                     rx_data, rx_valid, frame_error, parity_error, rx_busy);
        end
        nRST = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        n_cmp++;
        if (rx_busy !== 1'b0 || clear !== 1'b1) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b clr=%b, wanted busy=0 clr=1", rx_busy, clear);
        end
    endtask

    task automatic test_single_byte();
        int c0;
        int lat;
        align();
        c0 = cycle;
        expect_valid(8'hA5);
        send_frame(8'hA5, ^8'hA5, 1'b1);
        wait_drain("byte_a5");
        lat = last_evt_cycle - c0;
        n_cmp++;
        if (lat < 150 || lat > 162) begin
            n_err++;
            $display("FAIL byte_a5_latency: got %0d cycles, wanted 150..162", lat);
        end
        n_cmp++;
        if (rx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL byte_a5_hold: got %h, wanted a5", rx_data);
        end
    endtask

    task automatic test_reset_midframe();
        align();
        rx = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        n_cmp++;
        if (rx_busy !== 1'b1 || enableCounter !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_busy: got busy=%b en=%b, wanted 1 1", rx_busy, enableCounter);
        end
        nRST = 1'b0;
        #1;
        n_cmp++;
        if ({rx_data, rx_busy, enableCounter, clear, maxCount} !== {8'h00, 1'b0, 1'b0, 1'b1, CW'(0)}) begin
            n_err++;
            $display("FAIL midframe_reset: got data=%h busy=%b en=%b clr=%b max=%0d, wanted 00 0 0 1 0",
                     rx_data, rx_busy, enableCounter, clear, maxCount);
        end
        last_good = 8'h00;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nRST = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        n_cmp++;
        if (rx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_recover: got busy=%b, wanted 0", rx_busy);
        end
    endtask

    task automatic test_glitch();
        align();
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        n_cmp++;
        if (rx_busy !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_start: got busy=%b, wanted 1", rx_busy);
        end
        repeat (30) @(posedge clk);
        #1;
        n_cmp++;
        if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin
            n_err++;
            $display("FAIL glitch_return: got busy=%b data=%h, wanted 0 00", rx_busy, rx_data);
        end
    endtask

    task automatic test_frame_error();
        align();
        expect_valid(8'h96);
        send_frame(8'h96, ^8'h96, 1'b1);
        wait_drain("pre_ferr");
        align();
        expect_ferr();
        send_frame(8'h3C, ^8'h3C, 1'b0);
        wait_drain("ferr");
        n_cmp++;
        if (rx_data !== 8'h96 || rx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL ferr_hold: got data=%h busy=%b, wanted 96 0", rx_data, rx_busy);
        end
    endtask

    task automatic test_back_to_back();
        align();
        n_7to15 = 0;
        expect_valid(8'h00);
        expect_valid(8'hFF);
        send_frame(8'h00, ^8'h00, 1'b1);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        wait_drain("b2b");
        n_cmp++;
        if (n_7to15 != 2) begin
            n_err++;
            $display("FAIL b2b_maxcount_steps: got %0d 7->15 steps, wanted 2", n_7to15);
        end
        n_cmp++;
        if (rx_data !== 8'hFF) begin
            n_err++;
            $display("FAIL b2b_hold: got %h, wanted ff", rx_data);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        align();
        expect_perr();
        send_frame(8'h01, 1'b0, 1'b1);
        wait_drain("parity_bad");
        n_cmp++;
        if (rx_data !== 8'hFF) begin
            n_err++;
            $display("FAIL parity_bad_hold: got %h, wanted ff", rx_data);
        end
        align();
        expect_valid(8'h01);
        send_frame(8'h01, 1'b1, 1'b1);
        wait_drain("parity_good");
    endtask
`endif

    initial begin
        rx   = 1'b1;
        nRST = 1'b0;
        test_reset();
        test_single_byte();
        test_reset_midframe();
        test_glitch();
        test_frame_error();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
